// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong delay line and its noise source.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    RUN    = 2'd2
  } ks_dl_state_t;

  localparam logic [15:0] KS_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] KS_LFSR_SEED = 16'hACE1;
  localparam int          KS_MIN_LEN   = 2;

  function automatic logic [15:0] ks_lfsr_step(input logic [15:0] cur);
    ks_lfsr_step = cur[0] ? ((cur >> 1) ^ KS_LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/ks_delay_line_if.sv
// Control, feedback and output bundle between the voice controller, the delay line and the filter.
interface ks_delay_line_if #(
  parameter int BIT_WIDTH = 16,
  parameter int ADDR_W    = 11
);
  logic                 sample_tick;
  logic                 pluck;
  logic [ADDR_W:0]      period;
  logic [1:0]           amp;
  logic [BIT_WIDTH-1:0] fb_in;
  logic [BIT_WIDTH-1:0] dl_out;
  logic                 dl_valid;
  logic                 busy;

  modport master (
    output sample_tick, pluck, period, amp, fb_in,
    input  dl_out, dl_valid, busy
  );

  modport slave (
    input  sample_tick, pluck, period, amp, fb_in,
    output dl_out, dl_valid, busy
  );
endinterface

// File: rtl/ks_noise_lfsr.sv
// 16-bit Galois LFSR noise source; reseeded only by reset so successive plucks differ.
module ks_noise_lfsr
  import ks_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] noise
);

  logic [15:0] state_r;

  // LFSR state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= KS_LFSR_SEED;
    end else if (en) begin
      state_r <= ks_lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign noise = state_r;

endmodule

// File: rtl/ks_delay_line.sv
// Karplus-Strong excitation and circular delay line: fills with shaped LFSR noise on pluck,
// then emits the oldest sample and stores the filter's return on every sample tick.
module ks_delay_line
  import ks_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int MAX_LEN   = 2048,
  parameter int ADDR_W    = $clog2(MAX_LEN)
) (
  input  logic             m_clk,
  input  logic             reset,
  ks_delay_line_if.slave   bus
);

  localparam logic [ADDR_W:0]   MIN_LEN_C = (ADDR_W+1)'(KS_MIN_LEN);
  localparam logic [ADDR_W:0]   MAX_LEN_C = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE_C = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ZERO_C = ADDR_W'(1'b0);

  ks_dl_state_t         state_r, state_next_s;
  logic [ADDR_W-1:0]    ptr_r, ptr_next_s;
  logic [ADDR_W:0]      len_r, len_next_s, len_clamped_s;
  logic                 busy_r;
  logic                 dl_valid_r;
  logic                 zero_sel_r;
  logic [BIT_WIDTH-1:0] rd_q_r;
  logic [BIT_WIDTH-1:0] mem [MAX_LEN];
  logic                 ram_we_s, ram_rd_s, lfsr_en_s, last_s;
  logic [BIT_WIDTH-1:0] ram_wdata_s, shaped_s;
  logic [15:0]          noise_s;

  ks_noise_lfsr u_lfsr (
    .clk   (m_clk),
    .reset (reset),
    .en    (lfsr_en_s),
    .noise (noise_s)
  );

  assign shaped_s = $signed(noise_s) >>> bus.amp;
  assign last_s   = ({1'b0, ptr_r} == (len_r - LEN_ONE_C));

  // Clamp the requested period into the supported delay range
  always_comb begin
    if (bus.period < MIN_LEN_C) begin
      len_clamped_s = MIN_LEN_C;
    end else if (bus.period > MAX_LEN_C) begin
      len_clamped_s = MAX_LEN_C;
    end else begin
      len_clamped_s = bus.period;
    end
  end

  // Next-state, pointer and RAM port control
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    len_next_s   = len_r;
    ram_we_s     = 1'b0;
    ram_rd_s     = 1'b0;
    ram_wdata_s  = bus.fb_in;
    lfsr_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.pluck) begin
          state_next_s = EXCITE;
          ptr_next_s   = PTR_ZERO_C;
          len_next_s   = len_clamped_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXCITE: begin
        lfsr_en_s   = 1'b1;
        ram_we_s    = 1'b1;
        ram_wdata_s = shaped_s;
        if (last_s) begin
          state_next_s = RUN;
          ptr_next_s   = PTR_ZERO_C;
        end else begin
          ptr_next_s = ptr_r + PTR_ONE_C;
        end
      end
      RUN: begin
        // A simultaneous tick is swallowed: the restart takes priority over recirculation
        if (bus.pluck) begin
          state_next_s = EXCITE;
          ptr_next_s   = PTR_ZERO_C;
          len_next_s   = len_clamped_s;
        end else if (bus.sample_tick) begin
          ram_we_s   = 1'b1;
          ram_rd_s   = 1'b1;
          ptr_next_s = last_s ? PTR_ZERO_C : (ptr_r + PTR_ONE_C);
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
        ptr_next_s   = PTR_ZERO_C;
      end
    endcase
  end

  // Control and output-qualifier registers
  always_ff @(posedge m_clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_ZERO_C;
      len_r      <= MIN_LEN_C;
      busy_r     <= 1'b0;
      dl_valid_r <= 1'b0;
      zero_sel_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      ptr_r      <= ptr_next_s;
      len_r      <= len_next_s;
      busy_r     <= (state_next_s == EXCITE);
      dl_valid_r <= bus.sample_tick;
      if (bus.sample_tick) begin
        zero_sel_r <= !ram_rd_s;
      end else begin
        zero_sel_r <= zero_sel_r;
      end
    end
  end

  // Single-port read-first sample RAM; contents survive reset
  always_ff @(posedge m_clk) begin
    if (ram_we_s) begin
      mem[ptr_r] <= ram_wdata_s;
    end
    if (ram_rd_s) begin
      rd_q_r <= mem[ptr_r];
    end
  end

  assign bus.dl_out   = zero_sel_r ? {BIT_WIDTH{1'b0}} : rd_q_r;
  assign bus.dl_valid = dl_valid_r;
  assign bus.busy     = busy_r;

endmodule
